bus_responder: RTL and testbench

- Memory-side responder for the processor's multiplexed external bus.
- Accepts a 16-bit address strobed by ALE and decodes it against a base window.
- Serves reads and writes from an internal word-addressed RAM, inserting a programmable number of wait states through nWait.
- Used as on-chip program/data memory and as a bus-level model for core verification.

---
 rtl/bus_responder_pkg.sv | 15 +
 rtl/bus_responder_ram.sv | 23 ++
 rtl/bus_responder.sv | 140 ++++++++++++++
 tb/tb_bus_responder.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/bus_responder_pkg.sv
// Shared types and limits for the multiplexed-bus memory responder.
package bus_responder_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        WAIT,
        ACCESS,
        HOLD
    } bus_resp_state_t;

    localparam int WAIT_CNT_W      = 4;
    localparam int MAX_WAIT_STATES = (1 << WAIT_CNT_W) - 1;

endpackage

// File: rtl/bus_responder_ram.sv
// Single-port word RAM: synchronous write, synchronous read, write wins on a shared cycle.
module bus_responder_ram #(
    parameter int ADDR_W = 10
) (
    input  logic              Clock,
    input  logic              We,
    input  logic              Re,
    input  logic [ADDR_W-1:0] Addr,
    input  logic [15:0]       Wd,
    output logic [15:0]       Rd
);

    logic [15:0] mem [2**ADDR_W];

    always_ff @(posedge Clock) begin
        if (We) begin
            mem[Addr] <= Wd;
        end else if (Re) begin
            Rd <= mem[Addr];
        end
    end

endmodule

// File: rtl/bus_responder.sv
// Memory-side responder for the multiplexed external bus with programmable wait states.
// Optional write protection of the low window region: define BUS_RESPONDER_PROTECT_EN.
module bus_responder
    import bus_responder_pkg::*;
#(
    parameter int          ADDR_W      = 10,
    parameter logic [15:0] BASE        = 16'h0000,
    parameter int          WAIT_STATES = 1
`ifdef BUS_RESPONDER_PROTECT_EN
    ,
    parameter logic [15:0] PROTECT_TOP = 16'h0040
`endif
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic [15:0] BusIn,
    input  logic        ALE,
    input  logic        nME,
    input  logic        nOE,
    input  logic        RnW,
    output logic [15:0] BusOut,
    output logic        BusOutEn,
    output logic        nWait,
    output logic        Selected
`ifdef BUS_RESPONDER_PROTECT_EN
    ,
    output logic        ProtFault
`endif
);

    localparam logic [WAIT_CNT_W-1:0] WAIT_INIT =
        WAIT_CNT_W'((WAIT_STATES > 0) ? (WAIT_STATES - 1) : 0);

    bus_resp_state_t       state;
    logic [WAIT_CNT_W-1:0] cnt;
    logic [ADDR_W-1:0]     addrOff;
    logic [15:0]           ramRd;
    logic                  commit;
    logic                  writeOk;
    logic                  ramWe;
    logic                  ramRe;

`ifdef BUS_RESPONDER_PROTECT_EN
    assign writeOk = (16'(addrOff) >= PROTECT_TOP);
`else
    assign writeOk = 1'b1;
`endif

    // An ALE on the commit edge aborts the access, so it also suppresses the write.
    assign commit = !ALE && (state == ACCESS) && !nME && !RnW;
    assign ramWe  = commit && writeOk;
    // Prefetch while the address is stable so the registered RAM output is ready at ACCESS.
    assign ramRe  = (state == ADDR) || (state == WAIT);

    bus_responder_ram #(
        .ADDR_W(ADDR_W)
    ) ram (
        .Clock(Clock),
        .We   (ramWe),
        .Re   (ramRe),
        .Addr (addrOff),
        .Wd   (BusIn),
        .Rd   (ramRd)
    );

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state    <= IDLE;
            cnt      <= '0;
            addrOff  <= '0;
            Selected <= 1'b0;
            BusOut   <= '0;
            BusOutEn <= 1'b0;
            nWait    <= 1'b1;
`ifdef BUS_RESPONDER_PROTECT_EN
            ProtFault <= 1'b0;
`endif
        end else begin
`ifdef BUS_RESPONDER_PROTECT_EN
            ProtFault <= commit && !writeOk;
`endif
            if (ALE) begin
                addrOff  <= BusIn[ADDR_W-1:0];
                Selected <= (BusIn[15:ADDR_W] == BASE[15:ADDR_W]);
                state    <= ADDR;
                BusOutEn <= 1'b0;
                nWait    <= 1'b1;
            end else begin
                case (state)
                    IDLE: ;
                    ADDR: begin
                        if (!nME) begin
                            if (!Selected) begin
                                state <= HOLD;
                            end else if (WAIT_STATES == 0) begin
                                state <= ACCESS;
                            end else begin
                                state <= WAIT;
                                cnt   <= WAIT_INIT;
                                nWait <= 1'b0;
                            end
                        end
                    end
                    WAIT: begin
                        if (nME) begin
                            state <= IDLE;
                            nWait <= 1'b1;
                        end else if (cnt == '0) begin
                            state <= ACCESS;
                            nWait <= 1'b1;
                        end else begin
                            cnt <= cnt - 1'b1;
                        end
                    end
                    ACCESS: begin
                        if (nME) begin
                            state <= IDLE;
                        end else if (!RnW) begin
                            state <= HOLD;
                        end else if (!nOE) begin
                            BusOut   <= ramRd;
                            BusOutEn <= 1'b1;
                            state    <= HOLD;
                        end
                    end
                    HOLD: begin
                        if (nME) begin
                            state    <= IDLE;
                            BusOutEn <= 1'b0;
                        end else begin
                            BusOutEn <= BusOutEn & !nOE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_bus_responder.sv
// Self-checking bench for bus_responder: three instances (1, 0 and 3 wait states) against a
// transaction-level memory model. Define BUS_RESPONDER_PROTECT_EN to also cover write protection.
`timescale 1ns/1ps
module tb_bus_responder;

    localparam int WS [3] = '{1, 0, 3};

    logic        clk;
    logic        rst;
    logic [15:0] busIn    [3];
    logic [15:0] busOut   [3];
    logic        ale      [3];
    logic        nMe      [3];
    logic        nOe      [3];
    logic        rnw      [3];
    logic        busOutEn [3];
    logic        nWait    [3];
    logic        selected [3];
`ifdef BUS_RESPONDER_PROTECT_EN
    logic        protFault [3];
`endif

    logic [15:0] mem   [3][1024];
    bit          known [3][1024];
    int          tests;
    int          failed;

    bus_responder #(.ADDR_W(10), .BASE(16'h0000), .WAIT_STATES(1)) dut0 (
        .Clock(clk), .Reset(rst), .BusIn(busIn[0]), .ALE(ale[0]), .nME(nMe[0]), .nOE(nOe[0]),
        .RnW(rnw[0]), .BusOut(busOut[0]), .BusOutEn(busOutEn[0]), .nWait(nWait[0]),
        .Selected(selected[0])
`ifdef BUS_RESPONDER_PROTECT_EN
        , .ProtFault(protFault[0])
`endif
    );

    bus_responder #(.ADDR_W(10), .BASE(16'h0000), .WAIT_STATES(0)) dut1 (
        .Clock(clk), .Reset(rst), .BusIn(busIn[1]), .ALE(ale[1]), .nME(nMe[1]), .nOE(nOe[1]),
        .RnW(rnw[1]), .BusOut(busOut[1]), .BusOutEn(busOutEn[1]), .nWait(nWait[1]),
        .Selected(selected[1])
`ifdef BUS_RESPONDER_PROTECT_EN
        , .ProtFault(protFault[1])
`endif
    );

    bus_responder #(.ADDR_W(10), .BASE(16'h0000), .WAIT_STATES(3)) dut2 (
        .Clock(clk), .Reset(rst), .BusIn(busIn[2]), .ALE(ale[2]), .nME(nMe[2]), .nOE(nOe[2]),
        .RnW(rnw[2]), .BusOut(busOut[2]), .BusOutEn(busOutEn[2]), .nWait(nWait[2]),
        .Selected(selected[2])
`ifdef BUS_RESPONDER_PROTECT_EN
        , .ProtFault(protFault[2])
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input int d, input string tag, input logic [15:0] got,
                         input logic [15:0] exp);
        tests++;
        assert (got === exp) else begin
            failed++;
            $error("FAIL dut%0d %s: got %h, expected %h", d, tag, got, exp);
        end
    endtask

    // One complete bus cycle; expectations come from the window/latency rules and the model.
    task automatic busTxn(input int d, input logic [15:0] addr, input bit rd,
                          input logic [15:0] wd);
        int  ws;
        int  off;
        bit  hit;
        bit  prot;
        ws   = WS[d];
        off  = int'(addr[9:0]);
        hit  = (addr[15:10] == 6'd0);
        prot = 1'b0;
`ifdef BUS_RESPONDER_PROTECT_EN
        prot = !rd && (off < 'h40);
`endif
        @(negedge clk);
        ale[d] = 1'b1; busIn[d] = addr; nMe[d] = 1'b1; nOe[d] = 1'b1; rnw[d] = rd;
        @(negedge clk);
        check(d, "selected", 16'(selected[d]), 16'(hit));
        ale[d] = 1'b0; nMe[d] = 1'b0; nOe[d] = !rd; busIn[d] = rd ? 16'h0000 : wd;
        for (int j = 0; j <= ws + 1; j++) begin
            @(negedge clk);
            check(d, $sformatf("nWait@%0d", j), 16'(nWait[d]), 16'(!(hit && j < ws)));
            check(d, $sformatf("busOutEn@%0d", j), 16'(busOutEn[d]),
                  16'(hit && rd && j == ws + 1));
            if (hit && rd && j == ws + 1 && known[d][off])
                check(d, $sformatf("busOut[%0h]", off), busOut[d], mem[d][off]);
`ifdef BUS_RESPONDER_PROTECT_EN
            check(d, $sformatf("protFault@%0d", j), 16'(protFault[d]),
                  16'(hit && prot && j == ws + 1));
`endif
        end
        nMe[d] = 1'b1; nOe[d] = 1'b1;
        @(negedge clk);
        check(d, "busOutEnOff", 16'(busOutEn[d]), 16'h0000);
        if (hit && !rd && !prot) begin
            mem[d][off]   = wd;
            known[d][off] = 1'b1;
        end
    endtask

    initial begin
        tests  = 0;
        failed = 0;
        for (int d = 0; d < 3; d++) begin
            busIn[d] = 16'h0000; ale[d] = 1'b0; nMe[d] = 1'b1; nOe[d] = 1'b1; rnw[d] = 1'b1;
        end
        rst = 1'b1;
        repeat (2) @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            check(d, "rstBusOut", busOut[d], 16'h0000);
            check(d, "rstBusOutEn", 16'(busOutEn[d]), 16'h0000);
            check(d, "rstNWait", 16'(nWait[d]), 16'h0001);
            check(d, "rstSelected", 16'(selected[d]), 16'h0000);
        end
        rst = 1'b0;

        // Write then read back, one and zero wait states.
        busTxn(0, 16'h0005, 1'b0, 16'hBEEF);
        busTxn(0, 16'h0005, 1'b1, 16'h0000);
        busTxn(1, 16'h0003, 1'b0, 16'hC0DE);
        busTxn(1, 16'h0003, 1'b1, 16'h0000);

        // Outside the window: no response, RAM untouched.
        busTxn(0, 16'h0800, 1'b1, 16'h0000);
        busTxn(0, 16'h0805, 1'b0, 16'hDEAD);
        busTxn(0, 16'h0005, 1'b1, 16'h0000);

        // nME released after two of three wait cycles: write is abandoned.
        busTxn(2, 16'h0007, 1'b0, 16'h5555);
        @(negedge clk);
        ale[2] = 1'b1; busIn[2] = 16'h0007; rnw[2] = 1'b0; nMe[2] = 1'b1;
        @(negedge clk);
        ale[2] = 1'b0; nMe[2] = 1'b0; busIn[2] = 16'h1234;
        @(negedge clk);
        check(2, "abortWait0", 16'(nWait[2]), 16'h0000);
        @(negedge clk);
        check(2, "abortWait1", 16'(nWait[2]), 16'h0000);
        nMe[2] = 1'b1;
        @(negedge clk);
        check(2, "abortNWait", 16'(nWait[2]), 16'h0001);
        check(2, "abortBusOutEn", 16'(busOutEn[2]), 16'h0000);
        busTxn(2, 16'h0007, 1'b1, 16'h0000);

        // ALE arriving on the commit edge aborts the write.
        busTxn(0, 16'h0009, 1'b0, 16'h1111);
        @(negedge clk);
        ale[0] = 1'b1; busIn[0] = 16'h0009; rnw[0] = 1'b0; nMe[0] = 1'b1;
        @(negedge clk);
        ale[0] = 1'b0; nMe[0] = 1'b0; busIn[0] = 16'h7777;
        repeat (2) @(negedge clk);
        ale[0] = 1'b1; busIn[0] = 16'h000A;
        @(negedge clk);
        check(0, "aleAbortNWait", 16'(nWait[0]), 16'h0001);
        check(0, "aleAbortSelected", 16'(selected[0]), 16'h0001);
        ale[0] = 1'b0; nMe[0] = 1'b1;
        busTxn(0, 16'h0009, 1'b1, 16'h0000);

        // Asynchronous reset in the middle of a wait sequence.
        @(negedge clk);
        ale[2] = 1'b1; busIn[2] = 16'h0007; rnw[2] = 1'b1; nMe[2] = 1'b1; nOe[2] = 1'b1;
        @(negedge clk);
        ale[2] = 1'b0; nMe[2] = 1'b0; nOe[2] = 1'b0;
        @(negedge clk);
        check(2, "preRstNWait", 16'(nWait[2]), 16'h0000);
        #2 rst = 1'b1;
        #1;
        check(2, "asyncRstNWait", 16'(nWait[2]), 16'h0001);
        check(2, "asyncRstBusOutEn", 16'(busOutEn[2]), 16'h0000);
        check(2, "asyncRstSelected", 16'(selected[2]), 16'h0000);
        @(negedge clk);
        rst = 1'b0; nMe[2] = 1'b1; nOe[2] = 1'b1;
        busTxn(2, 16'h0007, 1'b1, 16'h0000);

`ifdef BUS_RESPONDER_PROTECT_EN
        busTxn(0, 16'h0010, 1'b0, 16'hAAAA);
        busTxn(0, 16'h0040, 1'b0, 16'hAAAA);
        busTxn(0, 16'h0040, 1'b1, 16'h0000);
`endif

        // Randomised traffic over a small offset range so reads revisit written words.
        for (int d = 0; d < 3; d++) begin
            for (int n = 0; n < 25; n++) begin
                logic [15:0] a;
                a = 16'($urandom_range(0, 127));
                if ($urandom_range(0, 7) == 0)
                    a[15:10] = 6'($urandom_range(1, 63));
                busTxn(d, a, 1'($urandom_range(0, 1)), 16'($urandom));
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
